serv_uart_rx_wb: RTL and testbench
==================================

// Module: serv_uart_rx_wb
// PURPOSE
//  Downstream consumer of one SERV core's serial TX pin (io_out[10] / [17] / [24]).
//  Recovers 8N1 UART bytes into a FIFO; the management SoC reads them over the
//  Caravel Wishbone slave port, so firmware on each core can be observed on-chip.
//  One instance per core, instantiated in the user project wrapper.
// PARAMETERS
//  CLKS_PER_BIT  104  wb_clk_i cycles per UART bit (>=4)
//  FIFO_DEPTH    8    byte FIFO entries, power of 2, 2..8
// PORTS
//  wb_clk_i    in   1   sole clock
//  wb_rst_n    in   1   asynchronous active-low reset
//  rx_i        in   1   serial line from SERV TX, idle high, asynchronous to wb_clk_i
//  wbs_cyc_i   in   1   Wishbone cycle
//  wbs_stb_i   in   1   Wishbone strobe (block already address-selected upstream)
//  wbs_we_i    in   1   1 = write
//  wbs_sel_i   in   4   byte lanes
//  wbs_adr_i   in   32  only bit [2] decoded: 0 = DATA, 1 = STATUS
//  wbs_dat_i   in   32  write data
//  wbs_ack_o   out  1   single-cycle acknowledge
//  wbs_dat_o   out  32  read data
//  irq_o       out  1   high while FIFO non-empty
// BEHAVIOUR
//  Reset: all outputs 0; synchronizer flops 1; FSM IDLE; FIFO empty; sticky flags 0.
//  rx_i passes a 2-flop synchronizer (reset value 1) -> rxs; all sampling uses rxs.
//  RX FSM, bit timer counts wb_clk_i cycles:
//   IDLE: rxs==0 -> START, timer = CLKS_PER_BIT/2-1.
//   START: at timer 0 sample; rxs==1 -> IDLE (glitch, nothing recorded); else DATA.
//   DATA: 8 samples, one every CLKS_PER_BIT cycles, LSB first, into shift reg.
//   STOP: sample after a further CLKS_PER_BIT cycles. rxs==1 -> push byte, IDLE.
//         rxs==0 -> set frame_err, no push, go to BREAK.
//   BREAK: wait for rxs==1, then IDLE.
//  Push while full (and no pop in that cycle): byte dropped, overflow set.
//  FIFO: count width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
//   Push and pop in the same cycle: both take effect, count unchanged, no overflow even when full.
//  Wishbone: ack asserts for one cycle, in the cycle after cyc&stb rises with ack low.
//   Back-to-back requests are acked every other cycle. wbs_dat_o is 0 whenever ack=0.
//   Read DATA: {24'b0, head byte}; FIFO pops in the ack cycle. If empty: returns 0, no pop.
//   Read STATUS: [0] not-empty, [1] full, [2] overflow, [3] frame_err,
//     [11:8] count, all other bits 0.
//   Write STATUS with sel[0]=1: bits [2] and [3] are write-1-to-clear. A set event in
//     the same cycle as a clear wins (flag stays 1).
//   Write DATA: acked, ignored. sel lanes other than [0] are ignored.
//  irq_o = registered FIFO not-empty: rises 1 cycle after the push, falls 1 cycle after
//   the pop that empties the FIFO.
//  Reset mid-frame: partial byte discarded. First frame after reset is received normally.
// TESTING  (CLKS_PER_BIT=8, FIFO_DEPTH=8)
//  Send 0x55 -> irq_o=1; STATUS reads 0x101; DATA reads 0x55; STATUS then reads 0x000; irq_o=0.
//  Send 0x00..0x08 without reading -> STATUS 0x807 (count 8, full, overflow, valid);
//   DATA reads 0x00..0x07 in order, then returns 0 with no pop.
//  Send 0xA5 with stop bit 0 -> STATUS 0x008, no byte; write STATUS 0x8 -> reads 0x000.
//  Drive rx_i low for 2 cycles then high -> no byte, no error, STATUS 0x000.
//  Count 3, frame stop-sample coincides with DATA-read ack -> count stays 3, order preserved.
//  Assert wb_rst_n low during bit 4 of a frame -> outputs 0, STATUS 0x000;
//   next frame 0x3C is read back as 0x3C.

Source files
------------

// File: rtl/serv_uart_rx_wb.sv
// serv_uart_rx_wb: 8N1 UART receiver that watches one SERV core's TX pin and
// queues the recovered bytes in a small FIFO. The management SoC reads the
// FIFO and the status flags through a Wishbone slave.
//
// Wishbone handshake: a request is (wbs_cyc_i & wbs_stb_i). wbs_ack_o rises in
// the cycle after a request is seen with ack low, and stays high for exactly
// one cycle. The request must be held until ack. All side effects (FIFO pop,
// flag clears) take place at the clock edge that ends the ack cycle.
// wbs_dat_o is forced to zero whenever ack is low.
module serv_uart_rx_wb #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        rx_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Half a bit minus one puts the start-bit sample mid-bit; later samples
    // follow at full bit intervals and therefore also land mid-bit.
    localparam logic [TMR_W-1:0] HALF_BIT = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_BIT = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_e;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic             rx_meta_q;
    logic             rxs_q;

    rx_state_e        state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             push;
    logic             frame_set;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             wr_en;
    logic             pop;
    logic             ovf_set;

    logic             ovf_q, ovf_d;
    logic             ferr_q, ferr_d;
    logic             irq_q, irq_d;
    logic             ack_q, ack_d;

    logic             wb_req;
    logic             rd_data;
    logic             st_wr;
    logic [7:0]       head_byte;
    logic [31:0]      status_word;
    logic [31:0]      dat_o_w;
    logic             unused_inputs;

    // Inputs that carry no meaning for this block (upstream decodes the
    // address; only byte lane 0 of a write is used).
    assign unused_inputs = ^{wbs_adr_i[31:3], wbs_adr_i[1:0], wbs_sel_i[3:1],
                             wbs_dat_i[31:4], wbs_dat_i[1:0]};

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous serial line (idles high)
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM state, bit timer, bit counter and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Receiver next state: every sample is taken when the bit timer hits 0
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    tmr_d   = HALF_BIT;
                end
            end
            S_START: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (rxs_q) begin
                    // Line came back high before mid start bit: a glitch.
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    tmr_d   = FULL_BIT;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else begin
                    // LSB arrives first, so shift in from the top.
                    shift_d = {rxs_q, shift_q[7:1]};
                    tmr_d   = FULL_BIT;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (rxs_q) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // Missing stop bit: drop the byte and wait out the low line.
                    frame_set = 1'b1;
                    state_d   = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Wishbone decode: effects happen at the end of the ack cycle
    // ------------------------------------------------------------------
    always_comb begin
        wb_req  = wbs_cyc_i & wbs_stb_i;
        ack_d   = wb_req & ~ack_q;
        rd_data = ack_q & ~wbs_we_i & ~wbs_adr_i[2];
        st_wr   = ack_q & wbs_we_i & wbs_adr_i[2] & wbs_sel_i[0];
    end

    // ------------------------------------------------------------------
    // FIFO next state: a simultaneous push and pop both proceed, even when full
    // ------------------------------------------------------------------
    always_comb begin
        fifo_full  = (count_q == CNT_FULL);
        fifo_empty = (count_q == '0);
        pop        = rd_data & ~fifo_empty;
        wr_en      = push & (~fifo_full | pop);
        ovf_set    = push & fifo_full & ~pop;

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wptr_q] = shift_q;
        end
        wptr_d = wptr_q + PTR_W'(wr_en);
        rptr_d = rptr_q + PTR_W'(pop);

        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins
    always_comb begin
        ovf_d  = (ovf_q & ~(st_wr & wbs_dat_i[2])) | ovf_set;
        ferr_d = (ferr_q & ~(st_wr & wbs_dat_i[3])) | frame_set;
        irq_d  = ~fifo_empty;
    end

    // FIFO storage, pointers, flags, interrupt and ack registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
            irq_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
            irq_q   <= irq_d;
            ack_q   <= ack_d;
        end
    end

    // Read data mux: zero outside the ack cycle and for writes
    always_comb begin
        head_byte   = fifo_empty ? 8'h00 : mem_q[rptr_q];
        status_word = {20'b0, 4'(count_q), 4'b0,
                       ferr_q, ovf_q, fifo_full, ~fifo_empty};
        dat_o_w     = '0;
        if (ack_q && !wbs_we_i) begin
            if (wbs_adr_i[2]) begin
                dat_o_w = status_word;
            end else begin
                dat_o_w = {24'b0, head_byte};
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_w;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_serv_uart_rx_wb.sv
// Testbench for serv_uart_rx_wb with CLKS_PER_BIT=8, FIFO_DEPTH=8.
module tb_serv_uart_rx_wb;

    localparam int CPB   = 8;
    localparam int DEPTH = 8;

    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic        irq;

    always #5 clk = ~clk;

    serv_uart_rx_wb #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .rx_i     (rx),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .irq_o    (irq)
    );

    // ---------------- scoreboard / reference model ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         m_ovf = 1'b0;
    bit         m_ferr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // A received frame either queues its byte, overflows, or flags a frame error.
    task automatic m_frame(input logic [7:0] b, input logic stop_v);
        if (!stop_v) m_ferr = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'h0;
        s[0]    = (exp_q.size() != 0);
        s[1]    = (exp_q.size() == DEPTH);
        s[2]    = m_ovf;
        s[3]    = m_ferr;
        s[11:8] = 4'(exp_q.size());
        return s;
    endfunction

    function automatic logic [31:0] m_read();
        logic [7:0] b;
        if (exp_q.size() == 0) return 32'h0;
        b = exp_q.pop_front();
        return {24'h0, b};
    endfunction

    task automatic m_reset();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // Start bit, 8 data bits LSB first, stop bit, each CPB cycles; line idles high after.
    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx = stop_v;
        repeat (CPB) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic wb_req(input logic we_v, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
        int n;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = we_v; adr = a; wdat = d; sel = s;
        @(negedge clk);
        check("dat_o_idle", rdat, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        check("ack_seen", {31'h0, ack}, 32'h1);
        r = rdat;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic rd_status(output logic [31:0] r);
        wb_req(1'b0, A_STATUS, 32'h0, 4'hf, r);
    endtask

    task automatic rd_data(output logic [31:0] r);
        wb_req(1'b0, A_DATA, 32'h0, 4'hf, r);
    endtask

    task automatic wr_status(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb_req(1'b1, A_STATUS, d, s, r);
        if (s[0]) begin
            if (d[2]) m_ovf = 1'b0;
            if (d[3]) m_ferr = 1'b0;
        end
    endtask

    task automatic check_irq(input string name);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(name, {31'h0, irq}, {31'h0, (exp_q.size() != 0)});
    endtask

    task automatic check_model_status(input string name);
        logic [31:0] r;
        rd_status(r);
        check(name, r, m_status());
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0]  byte_v;
        logic        stop_v;
        logic [31:0] exp_st1;
        logic [31:0] exp_dat;
        logic [31:0] clr;
        logic [31:0] exp_st2;
    } vec_t;

    vec_t vecs[4];

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r;
        int          n_ack;

        vecs[0] = '{8'h55, 1'b1, 32'h101, 32'h55, 32'h0, 32'h000};
        vecs[1] = '{8'hA5, 1'b0, 32'h008, 32'h00, 32'h8, 32'h000};
        vecs[2] = '{8'hC3, 1'b1, 32'h101, 32'hC3, 32'h0, 32'h000};
        vecs[3] = '{8'hFF, 1'b0, 32'h008, 32'h00, 32'h8, 32'h000};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        rd_status(r);
        check("rst_status", r, 32'h0);

        // Table: frame, STATUS, DATA, clear, STATUS
        for (int i = 0; i < 4; i++) begin
            send_frame(vecs[i].byte_v, vecs[i].stop_v);
            repeat (3) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].stop_v});
            rd_status(r);
            check($sformatf("vec%0d_st1", i), r, vecs[i].exp_st1);
            rd_data(r);
            check($sformatf("vec%0d_dat", i), r, vecs[i].exp_dat);
            wr_status(vecs[i].clr, 4'h1);
            rd_status(r);
            check($sformatf("vec%0d_st2", i), r, vecs[i].exp_st2);
            repeat (2) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_irq_low", i), {31'h0, irq}, 32'h0);
        end
        m_reset();

        // Glitch: two cycles low is not a start bit
        @(posedge clk); #1 rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        rd_status(r);
        check("glitch_status", r, 32'h000);

        // Overflow: nine frames into an eight-entry FIFO
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b1);
            m_frame(8'(i), 1'b1);
        end
        repeat (3) @(posedge clk);
        rd_status(r);
        check("ovf_status", r, 32'h807);
        check("ovf_status_model", r, m_status());
        for (int i = 0; i < 8; i++) begin
            rd_data(r);
            check($sformatf("ovf_data%0d", i), r, m_read());
        end
        rd_data(r);
        check("empty_read", r, 32'h0);
        rd_status(r);
        check("after_drain_status", r, 32'h004);
        wr_status(32'h4, 4'h1);
        check_model_status("ovf_cleared");

        // Count 3, stop-bit sample edge coincides with a DATA-read pop edge
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1);
            m_frame(8'h10 + 8'(i), 1'b1);
        end
        repeat (3) @(posedge clk);
        fork
            send_frame(8'h77, 1'b1);
            begin
                @(posedge clk);
                repeat (76) @(posedge clk);
                rd_data(r);
            end
        join
        check("coinc_read", r, m_read());
        m_frame(8'h77, 1'b1);
        repeat (3) @(posedge clk);
        rd_status(r);
        check("coinc_status", r, 32'h301);
        for (int i = 0; i < 3; i++) begin
            rd_data(r);
            check($sformatf("coinc_order%0d", i), r, m_read());
        end
        check_irq("coinc_irq");

        // Reset during bit 4 of a frame, with one byte already queued
        send_frame(8'h99, 1'b1);
        m_frame(8'h99, 1'b1);
        repeat (3) @(posedge clk);
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = i[0];
        end
        repeat (CPB) @(posedge clk);
        #1 rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        check("midrst_ack", {31'h0, ack}, 32'h0);
        check("midrst_dat", rdat, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        m_reset();
        repeat (20) @(posedge clk);
        rd_status(r);
        check("midrst_status", r, 32'h000);
        send_frame(8'h3C, 1'b1);
        repeat (3) @(posedge clk);
        rd_data(r);
        check("midrst_next_frame", r, 32'h3C);

        // Back-to-back request held for 4 cycles: ack every other cycle
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STATUS;
        n_ack = 0;
        repeat (4) begin
            @(negedge clk);
            n_ack += int'(ack);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        check("b2b_acks", 32'(n_ack), 32'd2);

        // Randomized traffic against the reference model
        for (int k = 0; k < 30; k++) begin
            int          op;
            logic [7:0]  b;
            logic        sv;
            logic [31:0] d;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                b  = 8'($urandom);
                sv = ($urandom_range(0, 7) != 0);
                send_frame(b, sv);
                m_frame(b, sv);
                repeat (3) @(posedge clk);
            end else if (op <= 6) begin
                rd_data(r);
                check("rand_data", r, m_read());
            end else if (op == 7) begin
                check_model_status("rand_status");
            end else if (op == 8) begin
                d = 32'($urandom_range(0, 15)) << 0;
                wr_status(d, 4'($urandom_range(0, 15)));
            end else begin
                wb_req(1'b1, A_DATA, $urandom, 4'hf, r);
            end
        end
        check_model_status("rand_final_status");
        check_irq("rand_final_irq");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
